// File: rtl/dmem_responder_if.sv
// Data-port bundle between the core's M stage and the data memory responder.
// The core drives address/strobe/data; the responder returns load data combinationally.
interface dmem_responder_if;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;

    modport master (
        output MemWriteM,
        output ALUResultM,
        output WriteDataM,
        input  ReadDataM
    );

    modport slave (
        input  MemWriteM,
        input  ALUResultM,
        input  WriteDataM,
        output ReadDataM
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus LED/cycle/store-counter window (DMEM_MMIO_EN).
// Latency: loads are zero-cycle combinational; stores commit on the rising edge.
// Backpressure: none, one access per cycle is always accepted; bad stores are dropped.
module dmem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_responder_if.slave        bus,
    output logic [31:0]            led_out,
    output logic                   access_err
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          mmio_win;
    logic          ram_hit;
    logic          mmio_hit;
    logic          aligned;
    logic          mapped;
    logic          store_ok;
    logic          bad_store;
    logic [31:0]   rdata;

    assign idx      = bus.ALUResultM[AW+1:2];
    assign mmio_win = (bus.ALUResultM[31:8] == MMIO_BASE[31:8]);
    // The peripheral window takes precedence should a tiny MMIO_BASE ever overlap RAM.
    assign ram_hit  = (bus.ALUResultM[31:AW+2] == '0) && !mmio_win;
    assign aligned  = (bus.ALUResultM[1:0] == 2'b00);
    assign mapped   = ram_hit || mmio_hit;
    assign store_ok = bus.MemWriteM && aligned && mapped;
    assign bad_store = bus.MemWriteM && !(aligned && mapped);

`ifdef DMEM_MMIO_EN
    logic [7:0]  offset;
    logic [31:0] led_q;
    logic [31:0] cycle_cnt;
    logic [31:0] store_cnt;

    assign offset   = bus.ALUResultM[7:0];
    assign mmio_hit = mmio_win &&
                      ((offset == 8'h00) || (offset == 8'h04) || (offset == 8'h08));
    assign led_out  = led_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            cycle_cnt <= '0;
            store_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (store_ok && mmio_hit && (offset == 8'h00)) begin
                led_q <= bus.WriteDataM;
            end
            // An explicit load of the store counter wins over counting; the two
            // cannot coincide anyway since only one access happens per cycle.
            if (store_ok && mmio_hit && (offset == 8'h08)) begin
                store_cnt <= bus.WriteDataM;
            end else if (store_ok && ram_hit && (store_cnt != '1)) begin
                store_cnt <= store_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = mem[idx];
        end else if (mmio_hit) begin
            case (offset)
                8'h00:   rdata = led_q;
                8'h04:   rdata = cycle_cnt;
                8'h08:   rdata = store_cnt;
                default: rdata = '0;
            endcase
        end
    end
`else
    assign mmio_hit = 1'b0;
    assign led_out  = '0;

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = mem[idx];
        end
    end
`endif

    assign bus.ReadDataM = rdata;

    // RAM has no reset; a store that coincides with reset must not land.
    always_ff @(posedge clk) begin
        if (!reset && store_ok && ram_hit) begin
            mem[idx] <= bus.WriteDataM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            access_err <= 1'b0;
        end else if (bad_store) begin
            access_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against an address-map reference model.
module tb_dmem_responder;
    localparam int unsigned DEPTH     = 256;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

    logic        clk;
    logic        reset;
    logic [31:0] led_out;
    logic        access_err;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .led_out    (led_out),
        .access_err (access_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    logic [31:0] ref_led;
    logic [31:0] ref_cyc;
    logic [31:0] ref_scnt;
    logic        ref_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return a < DEPTH * 4;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
        logic [31:0] off;
        if (a < MMIO_BASE) return 1'b0;
        off = a - MMIO_BASE;
        return (off == 0) || (off == 4) || (off == 8);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0 && (a != a);
`endif
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] exp, output bit valid);
        logic [31:0] wa;
        wa    = {a[31:2], 2'b00};
        exp   = '0;
        valid = 1'b1;
        if (is_ram(wa)) begin
            valid = ref_known[wa / 4];
            exp   = ref_mem[wa / 4];
        end else if (is_mmio(wa)) begin
            if (wa == MMIO_BASE)          exp = ref_led;
            else if (wa == MMIO_BASE + 4) exp = ref_cyc;
            else                          exp = ref_scnt;
        end
    endtask

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        ref_cyc = ref_cyc + 1;
        if (we) begin
            if ((a % 4 != 0) || !(is_ram(a) || is_mmio(a))) begin
                ref_err = 1'b1;
            end else if (is_ram(a)) begin
                ref_mem[a / 4]   = d;
                ref_known[a / 4] = 1'b1;
                if (ref_scnt != 32'hFFFF_FFFF) ref_scnt = ref_scnt + 1;
            end else if (a == MMIO_BASE) begin
                ref_led = d;
            end else if (a == MMIO_BASE + 8) begin
                ref_scnt = d;
            end
        end
    endtask

    task automatic model_reset();
        ref_led  = '0;
        ref_cyc  = '0;
        ref_scnt = '0;
        ref_err  = 1'b0;
    endtask

    // One access: drive after the falling edge, check the load, clock it, check flags.
    task automatic do_cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp;
        bit          valid;
        bus.MemWriteM  = we;
        bus.ALUResultM = a;
        bus.WriteDataM = d;
        #1;
        model_read(a, exp, valid);
        if (valid) check("rdata", bus.ReadDataM, exp);
        @(posedge clk);
        model_edge(we, a, d);
        @(negedge clk);
        check("led_out", led_out, ref_led);
        check("access_err", {31'd0, access_err}, {31'd0, ref_err});
        bus.MemWriteM = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] saved;
        int          sel;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        model_reset();
        reset          = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = '0;
        bus.WriteDataM = '0;
        #1;
        check("rst_led", led_out, 32'd0);
        check("rst_err", {31'd0, access_err}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Cycle counter: ten edges after release
        repeat (10) do_cycle(1'b0, 32'h0000_0020, 32'd0);
`ifdef DMEM_MMIO_EN
        do_cycle(1'b0, MMIO_BASE + 4, 32'd0);
        bus.ALUResultM = MMIO_BASE + 4;
        do_cycle(1'b1, MMIO_BASE + 4, 32'h1234_5678);
        check("cyc_ro_err", {31'd0, access_err}, 32'd0);
`endif

        // Store then load, with same-cycle old value visible
        do_cycle(1'b1, 32'h10, 32'h1111_1111);
        bus.MemWriteM = 1'b1; bus.ALUResultM = 32'h10; bus.WriteDataM = 32'hDEAD_BEEF;
        #1;
        check("same_cycle_old", bus.ReadDataM, 32'h1111_1111);
        @(posedge clk);
        model_edge(1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.MemWriteM = 1'b0;
        #1;
        check("load_new", bus.ReadDataM, 32'hDEAD_BEEF);
        check("no_err", {31'd0, access_err}, 32'd0);

`ifdef DMEM_MMIO_EN
        // LED register
        do_cycle(1'b1, MMIO_BASE, 32'h0000_00A5);
        check("led_a5", led_out, 32'h0000_00A5);
        do_cycle(1'b0, MMIO_BASE, 32'd0);
        // Store counter counting and saturation
        do_cycle(1'b1, MMIO_BASE + 8, 32'd0);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h40 + i * 4, $urandom);
        #1;
        bus.ALUResultM = MMIO_BASE + 8;
        #1;
        check("scnt_3", bus.ReadDataM, 32'd3);
        do_cycle(1'b1, MMIO_BASE + 8, 32'hFFFF_FFFE);
        for (int i = 0; i < 2; i++) do_cycle(1'b1, 32'h50 + i * 4, $urandom);
        bus.ALUResultM = MMIO_BASE + 8;
        #1;
        check("scnt_sat", bus.ReadDataM, 32'hFFFF_FFFF);
        @(negedge clk);
`endif

        // Misaligned and unmapped stores
        do_cycle(1'b1, 32'h12, 32'h5555_5555);
        check("err_misalign", {31'd0, access_err}, 32'd1);
        do_cycle(1'b1, DEPTH * 4, 32'h6666_6666);
        check("err_sticky", {31'd0, access_err}, 32'd1);
        bus.ALUResultM = 32'h10;
        #1;
        check("ram_kept", bus.ReadDataM, 32'hDEAD_BEEF);
        bus.ALUResultM = DEPTH * 4;
        #1;
        check("unmapped_rd", bus.ReadDataM, 32'd0);
        @(negedge clk);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                5:       a = $urandom_range(0, 31) * 4 + $urandom_range(1, 3);
                6:       a = DEPTH * 4 + $urandom_range(0, 1000) * 4;
                7:       a = MMIO_BASE + $urandom_range(0, 3) * 4;
                8:       a = MMIO_BASE + $urandom_range(0, 255);
                default: a = $urandom_range(0, 31) * 4;
            endcase
            do_cycle(1'($urandom_range(0, 1)), a, $urandom);
        end

`ifdef DMEM_MMIO_EN
        do_cycle(1'b1, MMIO_BASE, 32'h0000_00A5);
`endif
        do_cycle(1'b1, 32'h3, 32'h0);
        check("pre_rst_err", {31'd0, access_err}, 32'd1);

        // Asynchronous reset between edges, store held through it
        saved = ref_mem[4];
        #2;
        reset = 1'b1;
        #1;
        check("arst_led", led_out, 32'd0);
        check("arst_err", {31'd0, access_err}, 32'd0);
        model_reset();
        bus.MemWriteM = 1'b1; bus.ALUResultM = 32'h10; bus.WriteDataM = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        bus.MemWriteM = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_store_drop", bus.ReadDataM, saved);
        @(negedge clk);
`ifdef DMEM_MMIO_EN
        ref_cyc = 32'd1;
        bus.ALUResultM = MMIO_BASE + 4;
        #1;
        check("cyc_after_rst", bus.ReadDataM, 32'd1);
        @(negedge clk);
        ref_cyc = 32'd2;
        do_cycle(1'b0, MMIO_BASE + 4, 32'd0);
`else
        do_cycle(1'b1, MMIO_BASE, 32'h0000_00A5);
        check("nommio_err", {31'd0, access_err}, 32'd1);
        check("nommio_led", led_out, 32'd0);
        do_cycle(1'b0, MMIO_BASE, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
